// File: rtl/cmp_pkg.sv
// Shared types and constants for the registered magnitude comparator.
package cmp_pkg;

    // Operand width used when the parent does not override it.
    localparam int CMP_WIDTH_DEFAULT = 4;

    // One-hot compare result, packed as {B_GT_A, A_GT_B, EQ}.
    typedef logic [2:0] cmp_result_t;

    localparam cmp_result_t CMP_NONE = 3'b000;  // only seen in the reset state
    localparam cmp_result_t CMP_EQ   = 3'b001;
    localparam cmp_result_t CMP_AGT  = 3'b010;
    localparam cmp_result_t CMP_BGT  = 3'b100;

    // Folds an equal / A-greater decision into the one-hot encoding.
    // If the operands are neither equal nor A-greater, then B must be greater.
    function automatic cmp_result_t cmp_pack(input logic eq, input logic gt);
        cmp_result_t res;
        if (eq) begin
            res = CMP_EQ;
        end else if (gt) begin
            res = CMP_AGT;
        end else begin
            res = CMP_BGT;
        end
        return res;
    endfunction

endpackage

// File: rtl/cmp_core.sv
// Purely combinational magnitude compare with optional two's-complement
// interpretation of the operands.
module cmp_core
    import cmp_pkg::*;
#(
    parameter int WIDTH = CMP_WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_mode,
    output cmp_result_t      result
);

    localparam int MSB = WIDTH - 1;

    logic eq;
    logic gt_unsigned;
    logic gt;

    // Derive equality and A-greater. In signed mode, differing sign bits settle
    // the result: the non-negative operand wins. If the sign bits match, the
    // plain unsigned compare gives the same ordering as comparing the
    // remaining bits.
    always_comb begin
        eq          = (a == b);
        gt_unsigned = (a > b);
        gt          = gt_unsigned;
        if (signed_mode && (a[MSB] != b[MSB])) begin
            gt = b[MSB];
        end
        result = cmp_pack(eq, gt);
    end

endmodule

// File: rtl/comparator_unit.sv
// Registered magnitude comparator. The result appears one clock after it is
// sampled. The flags hold their value across idle cycles. out_valid marks
// cycles that carry a freshly sampled pair.
module comparator_unit
    import cmp_pkg::*;
#(
    parameter int WIDTH = CMP_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             EQ,
    output logic             A_GT_B,
    output logic             B_GT_A,
    output logic             out_valid
);

    cmp_result_t core_result;
    cmp_result_t result_q;

    cmp_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .a          (A),
        .b          (B),
        .signed_mode(signed_mode),
        .result     (core_result)
    );

    // Capture a new result only on valid cycles. out_valid tracks in_valid
    // one cycle late, and reset clears everything at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q  <= CMP_NONE;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                result_q <= core_result;
            end
        end
    end

    assign EQ     = result_q[0];
    assign A_GT_B = result_q[1];
    assign B_GT_A = result_q[2];

endmodule

// File: tb/tb_comparator_unit.sv
// Self-checking bench for comparator_unit: directed cases, an exhaustive
// 4-bit sweep, random traffic and a 1-bit instance, all scored against an
// integer-arithmetic reference model.
module tb_comparator_unit;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       signed_mode;
    logic [3:0] a;
    logic [3:0] b;
    logic       eq;
    logic       a_gt_b;
    logic       b_gt_a;
    logic       out_valid;

    logic       in_valid1;
    logic       signed_mode1;
    logic [0:0] a1;
    logic [0:0] b1;
    logic       eq1;
    logic       a_gt_b1;
    logic       b_gt_a1;
    logic       out_valid1;

    int         n_checks;
    int         n_fail;
    logic [2:0] exp_flags;
    logic       exp_valid;

    comparator_unit #(.WIDTH(4)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .signed_mode(signed_mode),
        .A          (a),
        .B          (b),
        .EQ         (eq),
        .A_GT_B     (a_gt_b),
        .B_GT_A     (b_gt_a),
        .out_valid  (out_valid)
    );

    comparator_unit #(.WIDTH(1)) u_dut1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid1),
        .signed_mode(signed_mode1),
        .A          (a1),
        .B          (b1),
        .EQ         (eq1),
        .A_GT_B     (a_gt_b1),
        .B_GT_A     (b_gt_a1),
        .out_valid  (out_valid1)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: turn both operands into signed integers, then compare them.
    // Returns {B>A, A>B, A==B}.
    function automatic logic [2:0] refCompare(input int w, input logic [3:0] av,
                                              input logic [3:0] bv, input logic mode);
        longint va;
        longint vb;
        va = longint'(av);
        vb = longint'(bv);
        if (mode && av[w-1]) va = va - (longint'(1) << w);
        if (mode && bv[w-1]) vb = vb - (longint'(1) << w);
        return {vb > va, va > vb, va == vb};
    endfunction

    task automatic checkOutput(input string tag, input logic [3:0] observed,
                               input logic [3:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got {valid,bgt,agt,eq}=%b, expected %b",
                     tag, observed, expected);
        end
    endtask

    // Drive one cycle on the 4-bit unit, update the model, and check after the edge.
    task automatic applyStimulus(input logic v, input logic mode, input logic [3:0] av,
                                 input logic [3:0] bv, input string tag);
        in_valid    = v;
        signed_mode = mode;
        a           = av;
        b           = bv;
        @(posedge clk);
        #1;
        if (v) exp_flags = refCompare(4, av, bv, mode);
        exp_valid = v;
        checkOutput(tag, {out_valid, b_gt_a, a_gt_b, eq}, {exp_valid, exp_flags});
    endtask

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        exp_flags    = 3'b000;
        exp_valid    = 1'b0;
        rst_n        = 1'b0;
        in_valid     = 1'b0;
        signed_mode  = 1'b0;
        a            = '0;
        b            = '0;
        in_valid1    = 1'b0;
        signed_mode1 = 1'b0;
        a1           = '0;
        b1           = '0;

        // Reset state, then release while idle.
        #3;
        checkOutput("reset", {out_valid, b_gt_a, a_gt_b, eq}, 4'b0000);
        @(posedge clk);
        #1;
        checkOutput("reset_clk", {out_valid, b_gt_a, a_gt_b, eq}, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 4'd3, 4'd1, "idle0");
        applyStimulus(1'b0, 1'b0, 4'd7, 4'd9, "idle1");

        // Directed unsigned and signed cases.
        applyStimulus(1'b1, 1'b0, 4'b0000, 4'b0001, "u_bgt");
        applyStimulus(1'b1, 1'b0, 4'b0011, 4'b0010, "u_agt");
        applyStimulus(1'b1, 1'b0, 4'b0100, 4'b0100, "u_eq");
        applyStimulus(1'b1, 1'b1, 4'b1000, 4'b0111, "s_neg8_vs_7");
        applyStimulus(1'b1, 1'b0, 4'b1000, 4'b0111, "u_8_vs_7");

        // Hold: flags persist and out_valid drops while inputs wander.
        applyStimulus(1'b1, 1'b0, 4'b1111, 4'b0000, "hold_set");
        applyStimulus(1'b0, 1'b0, 4'b0101, 4'b1001, "hold0");
        applyStimulus(1'b0, 1'b1, 4'b0010, 4'b0010, "hold1");

        // Reset between edges clears outputs immediately and drops the pending sample.
        applyStimulus(1'b1, 1'b0, 4'b1111, 4'b0000, "pre_rst");
        in_valid = 1'b1;
        a        = 4'd1;
        b        = 4'd9;
        #2;
        rst_n = 1'b0;
        #1;
        exp_flags = 3'b000;
        exp_valid = 1'b0;
        checkOutput("mid_rst", {out_valid, b_gt_a, a_gt_b, eq}, 4'b0000);
        @(posedge clk);
        #1;
        checkOutput("mid_rst_clk", {out_valid, b_gt_a, a_gt_b, eq}, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b1, 1'b0, 4'd2, 4'd9, "post_rst");

        // in_valid toggling every cycle.
        for (int i = 0; i < 10; i++) begin
            applyStimulus((i % 2) == 0, 1'(i / 2), 4'($urandom), 4'($urandom), "toggle");
        end

        // Exhaustive 4-bit sweep in both modes.
        for (int m = 0; m < 2; m++) begin
            for (int x = 0; x < 16; x++) begin
                for (int y = 0; y < 16; y++) begin
                    applyStimulus(1'b1, 1'(m), 4'(x), 4'(y), "sweep");
                end
            end
        end

        // Random traffic with random idle cycles.
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'($urandom_range(0, 3) != 0), 1'($urandom), 4'($urandom),
                          4'($urandom), "random");
        end

        // 1-bit instance: in signed mode a 1 means -1.
        in_valid = 1'b0;
        for (int m = 0; m < 2; m++) begin
            for (int x = 0; x < 2; x++) begin
                for (int y = 0; y < 2; y++) begin
                    in_valid1    = 1'b1;
                    signed_mode1 = 1'(m);
                    a1           = 1'(x);
                    b1           = 1'(y);
                    @(posedge clk);
                    #1;
                    checkOutput("w1", {out_valid1, b_gt_a1, a_gt_b1, eq1},
                                {1'b1, refCompare(1, 4'(x), 4'(y), 1'(m))});
                end
            end
        end
        in_valid1 = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("w1_hold", {out_valid1, b_gt_a1, a_gt_b1, eq1},
                    {1'b0, refCompare(1, 4'd1, 4'd1, 1'b1)});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
